sdram_arb: RTL and testbench
============================

# sdram_arb

Round-robin arbiter that shares the single-port SDRAM controller (25-bit word address, 32-bit data, 4-bit byte mask, valid/ready handshake) between `NPORTS` requesters, e.g. instruction fetch and data load/store of the core. It sits between the requesters and the controller. It latches one request at a time, forwards it downstream, and returns read data and a one-cycle `ready` pulse to the granted requester only.

## Interface
Parameters:
- `NPORTS`, 2: number of requester ports; must be at least 2.
- `ADDR_W`, 25: address width, matching the controller.
- `DATA_W`, 32: data width, matching the controller.

Ports (requester buses are flattened, port i occupies slice i):
- `clk` in 1: single clock, shared with the controller.
- `resetn` in 1: asynchronous, active-low reset.
- `s_valid` in NPORTS: request strobe per port, held until that port's `s_ready`.
- `s_addr` in NPORTS*ADDR_W: request address.
- `s_din` in NPORTS*DATA_W: write data.
- `s_wmask` in NPORTS*4: byte write mask; all-zero means read.
- `s_dout` out DATA_W: read data; one shared bus, valid with `s_ready`.
- `s_ready` out NPORTS: one-hot completion pulse.
- `m_valid` out 1: request to the controller.
- `m_addr` out ADDR_W.
- `m_din` out DATA_W.
- `m_wmask` out 4.
- `m_dout` in DATA_W: controller read data, valid with `m_ready`.
- `m_ready` in 1: controller completion pulse, one cycle.

## Operation
- Reset values: every output 0, state IDLE, `last` = NPORTS-1. Port 0 therefore wins the first contention.
- State IDLE
  - If `s_valid` is nonzero, pick the first requesting port searching `last+1, last+2, …`, wrapping modulo NPORTS.
  - Register the picked port's addr/din/wmask into `m_*`, set `m_valid`=1, `grant`=port, `last`=port.
  - Go to BUSY.
  - If no port requests, hold outputs and do nothing.
- State BUSY
  - `m_*` are held constant.
  - On `m_ready`=1: `m_valid`←0, `s_dout`←`m_dout` (also for writes, where the value is don't-care), `s_ready[grant]`←1. Go to RELEASE.
- State RELEASE
  - `s_ready`←0. No grant is made in this cycle, so the completed requester drops `s_valid` and the controller sees `m_valid` low.
  - Go to IDLE.
- Request fields are sampled only at grant. Changes on `s_*` of the granted port during BUSY are ignored.
- A port that deasserts `s_valid` before its `s_ready` (a protocol violation) still has its transaction completed and still receives the `s_ready` pulse.
- `m_ready` outside BUSY is ignored, with no state or output change.
- `s_dout` holds its last value until the next completion.
- A port keeping `s_valid` high after `s_ready` is treated as a new request. Round-robin guarantees each other requesting port is served first (bounded wait of NPORTS-1 transactions).
- Asynchronous reset mid-transaction returns all state to reset values immediately. The in-flight controller access is abandoned; the controller is reset from the same `resetn`.

## Timing
- `s_valid` seen in IDLE at cycle t produces `m_valid`=1 at t+1.
- `m_ready` at cycle u produces `s_ready[g]`=1 and `s_dout` valid at u+1, state IDLE at u+2, and the earliest next `m_valid` at u+3.
- Arbiter overhead is 3 cycles per transaction on top of controller latency.
- All outputs are registered. There are no combinational paths from `s_*` or `m_*` inputs to outputs.

## Structure
- Package `sdram_arb_pkg`:
  - State encoding: IDLE=0, BUSY=1, RELEASE=2, 2 bits.
  - `MASK_W`=4.
  - Width helper constants: `GRANT_W`=$clog2(NPORTS).
- Sub-module `rr_pick` (combinational):
  - Inputs: `req[NPORTS]`, `last`.
  - Outputs: `any`, `idx`.
  - Rotating priority search with wrap-around.
- Top: FSM, `grant`/`last` registers, request holding registers, output demux.

## Test plan
- Single read: port0 valid, addr=0x000123, wmask=0 → `m_valid` next cycle with `m_addr`=0x000123. After `m_ready` with `m_dout`=0xDEADBEEF: `s_ready`=2'b01 for exactly one cycle and `s_dout`=0xDEADBEEF.
- Contention: port0 and port1 valid in the same cycle after reset → port0 granted first, port1 second. `s_ready` never asserts for a non-granted port.
- Fairness: both ports hold valid continuously for 6 transactions → grants alternate 0,1,0,1,0,1. With NPORTS=3 and all requesting → 0,1,2,0.
- Write passthrough: port1 writes addr=0x1FFFFFF, din=0xA5A5_5A5A, wmask=4'b0110 → the `m_*` fields match exactly. The fields stay stable through BUSY even when `s_din` changes mid-transaction.
- Stray/ordering: `m_ready` pulsed while IDLE → no `s_ready`. Grant never occurs in the RELEASE cycle. Minimum gap between `m_valid` fall and next rise is 2 cycles.
- Reset mid-BUSY: drop `resetn` asynchronously → `m_valid`, `s_ready`, `s_dout` go to 0 without a clock edge. After release, the first contention grants port0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM requester arbiter.
// Holds the FSM encoding, the byte-mask width and the grant-index width helper.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int MASK_W = 4;

   function automatic int grant_w(input int nports);
      return (nports > 1) ? $clog2(nports) : 1;
   endfunction

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Rotating-priority picker: first requester after `last`, wrapping; `last` itself is lowest priority.
// Purely combinational, no state.
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NPORTS = 2,
   parameter int W      = grant_w(NPORTS)
) (
   input  logic [NPORTS-1:0] req,
   input  logic [W-1:0]      last,
   output logic              any,
   output logic [W-1:0]      idx
);

   logic [W-1:0] w_pos;

   // Walk from farthest to nearest so the port closest after `last` wins.
   always_comb begin
      any   = 1'b0;
      idx   = '0;
      w_pos = '0;
      for (int k = NPORTS; k >= 1; k--) begin
         w_pos = W'((int'(last) + k) % NPORTS);
         if (req[w_pos]) begin
            any = 1'b1;
            idx = w_pos;
         end
      end
   end

endmodule

// File: rtl/sdram_arb.sv
// Round-robin arbiter sharing one SDRAM controller among NPORTS requesters; fully registered outputs.
// Grant to m_valid is 1 cycle; m_ready to s_ready is 1 cycle; one RELEASE cycle before the next grant.
module sdram_arb
   import sdram_arb_pkg::*;
#(
   parameter int NPORTS = 2,
   parameter int ADDR_W = 25,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NPORTS-1:0]          s_valid,
   input  logic [NPORTS*ADDR_W-1:0]   s_addr,
   input  logic [NPORTS*DATA_W-1:0]   s_din,
   input  logic [NPORTS*MASK_W-1:0]   s_wmask,
   output logic [DATA_W-1:0]          s_dout,
   output logic [NPORTS-1:0]          s_ready,
   output logic                       m_valid,
   output logic [ADDR_W-1:0]          m_addr,
   output logic [DATA_W-1:0]          m_din,
   output logic [MASK_W-1:0]          m_wmask,
   input  logic [DATA_W-1:0]          m_dout,
   input  logic                       m_ready
);

   localparam int GRANT_W = grant_w(NPORTS);

   state_t              r_state,   w_state_nxt;
   logic [GRANT_W-1:0]  r_grant,   w_grant_nxt;
   logic [GRANT_W-1:0]  r_last,    w_last_nxt;
   logic                r_m_valid, w_m_valid_nxt;
   logic [ADDR_W-1:0]   r_m_addr,  w_m_addr_nxt;
   logic [DATA_W-1:0]   r_m_din,   w_m_din_nxt;
   logic [MASK_W-1:0]   r_m_wmask, w_m_wmask_nxt;
   logic [DATA_W-1:0]   r_s_dout,  w_s_dout_nxt;
   logic [NPORTS-1:0]   r_s_ready, w_s_ready_nxt;

   logic                w_any;
   logic [GRANT_W-1:0]  w_idx;

   rr_pick #(
      .NPORTS (NPORTS),
      .W      (GRANT_W)
   ) u_pick (
      .req  (s_valid),
      .last (r_last),
      .any  (w_any),
      .idx  (w_idx)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_last    <= GRANT_W'(NPORTS - 1);
         r_m_valid <= 1'b0;
         r_m_addr  <= '0;
         r_m_din   <= '0;
         r_m_wmask <= '0;
         r_s_dout  <= '0;
         r_s_ready <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_last    <= w_last_nxt;
         r_m_valid <= w_m_valid_nxt;
         r_m_addr  <= w_m_addr_nxt;
         r_m_din   <= w_m_din_nxt;
         r_m_wmask <= w_m_wmask_nxt;
         r_s_dout  <= w_s_dout_nxt;
         r_s_ready <= w_s_ready_nxt;
      end
   end

   // Request fields are captured only at grant, so requester changes during BUSY never leak downstream.
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_last_nxt    = r_last;
      w_m_valid_nxt = r_m_valid;
      w_m_addr_nxt  = r_m_addr;
      w_m_din_nxt   = r_m_din;
      w_m_wmask_nxt = r_m_wmask;
      w_s_dout_nxt  = r_s_dout;
      w_s_ready_nxt = r_s_ready;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_m_addr_nxt  = s_addr[w_idx*ADDR_W +: ADDR_W];
               w_m_din_nxt   = s_din[w_idx*DATA_W +: DATA_W];
               w_m_wmask_nxt = s_wmask[w_idx*MASK_W +: MASK_W];
               w_m_valid_nxt = 1'b1;
               w_grant_nxt   = w_idx;
               w_last_nxt    = w_idx;
               w_state_nxt   = BUSY;
            end
         end
         BUSY: begin
            if (m_ready) begin
               w_m_valid_nxt = 1'b0;
               w_s_dout_nxt  = m_dout;
               w_s_ready_nxt = {{(NPORTS-1){1'b0}}, 1'b1} << r_grant;
               w_state_nxt   = RELEASE;
            end
         end
         RELEASE: begin
            // Gives the finished requester a cycle to drop s_valid before arbitration resumes.
            w_s_ready_nxt = '0;
            w_state_nxt   = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign s_dout  = r_s_dout;
   assign s_ready = r_s_ready;
   assign m_valid = r_m_valid;
   assign m_addr  = r_m_addr;
   assign m_din   = r_m_din;
   assign m_wmask = r_m_wmask;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: a 2-port instance for the main sequence plus a 3-port instance for rotation.
module tb_sdram_arb;

   localparam int AW = 25;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              resetn;
   logic [1:0]        s_valid;
   logic [2*AW-1:0]   s_addr;
   logic [2*DW-1:0]   s_din;
   logic [7:0]        s_wmask;
   logic [DW-1:0]     s_dout;
   logic [1:0]        s_ready;
   logic              m_valid;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_din;
   logic [3:0]        m_wmask;
   logic [DW-1:0]     m_dout;
   logic              m_ready;

   logic [2:0]        s3_valid;
   logic [3*AW-1:0]   s3_addr;
   logic [3*DW-1:0]   s3_din;
   logic [11:0]       s3_wmask;
   logic [DW-1:0]     s3_dout;
   logic [2:0]        s3_ready;
   logic              m3_valid;
   logic [AW-1:0]     m3_addr;
   logic [DW-1:0]     m3_din;
   logic [3:0]        m3_wmask;
   logic [DW-1:0]     m3_dout;
   logic              m3_ready;

   int n_err = 0;
   int n_chk = 0;

   sdram_arb #(.NPORTS(2), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .s_valid (s_valid),
      .s_addr  (s_addr),
      .s_din   (s_din),
      .s_wmask (s_wmask),
      .s_dout  (s_dout),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_addr  (m_addr),
      .m_din   (m_din),
      .m_wmask (m_wmask),
      .m_dout  (m_dout),
      .m_ready (m_ready)
   );

   sdram_arb #(.NPORTS(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
      .clk     (clk),
      .resetn  (resetn),
      .s_valid (s3_valid),
      .s_addr  (s3_addr),
      .s_din   (s3_din),
      .s_wmask (s3_wmask),
      .s_dout  (s3_dout),
      .s_ready (s3_ready),
      .m_valid (m3_valid),
      .m_addr  (m3_addr),
      .m_din   (m3_din),
      .m_wmask (m3_wmask),
      .m_dout  (m3_dout),
      .m_ready (m3_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completes one 2-port transaction; exp_wait < 0 skips the grant-latency check.
   task automatic serve(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input bit keep, input int exp_wait);
      int cnt = 0;
      while (m_valid !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("grant_seen", m_valid, 1);
      if (exp_wait >= 0) chk("grant_latency", cnt, exp_wait);
      chk("grant_addr", m_addr, addr);
      tick();
      chk("busy_hold", {m_valid, s_ready}, 3'b100);
      m_dout  = data;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("done_ready", s_ready, 2'b01 << port);
      chk("done_dout", s_dout, data);
      chk("done_mvalid", m_valid, 0);
      if (!keep) s_valid[port] = 1'b0;
      tick();
      chk("release_quiet", {m_valid, s_ready}, 3'b000);
   endtask

   initial begin
      resetn   = 1'b0;
      s_valid  = '0;
      s_addr   = '0;
      s_din    = '0;
      s_wmask  = '0;
      m_dout   = '0;
      m_ready  = 1'b0;
      s3_valid = '0;
      s3_addr  = '0;
      s3_din   = '0;
      s3_wmask = '0;
      m3_dout  = '0;
      m3_ready = 1'b0;
      tick();
      tick();
      chk("rst_mvalid", m_valid, 0);
      chk("rst_sready", s_ready, 0);
      chk("rst_sdout", s_dout, 0);
      chk("rst_mfields", {m_addr, m_din, m_wmask}, 0);
      resetn = 1'b1;
      tick();

      // Single read from port 0
      s_addr[0 +: AW] = 25'h000123;
      s_valid = 2'b01;
      tick();
      chk("rd_mvalid", m_valid, 1);
      chk("rd_maddr", m_addr, 25'h000123);
      chk("rd_mwmask", m_wmask, 0);
      serve(0, 25'h000123, 32'hDEADBEEF, 1'b0, 0);
      tick();
      chk("rd_sdout_hold", s_dout, 32'hDEADBEEF);

      // Stray m_ready while IDLE
      m_dout  = 32'h1111_1111;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("stray_sready", s_ready, 0);
      chk("stray_mvalid", m_valid, 0);
      chk("stray_sdout", s_dout, 32'hDEADBEEF);
      tick();
      chk("stray_after", {m_valid, s_ready}, 3'b000);

      // Write passthrough from port 1, fields changed mid-transaction
      s_addr[AW +: AW]  = 25'h1FFFFFF;
      s_din[DW +: DW]   = 32'hA5A5_5A5A;
      s_wmask[7:4]      = 4'b0110;
      s_valid           = 2'b10;
      tick();
      chk("wr_mvalid", m_valid, 1);
      chk("wr_maddr", m_addr, 25'h1FFFFFF);
      chk("wr_mdin", m_din, 32'hA5A5_5A5A);
      chk("wr_mwmask", m_wmask, 4'b0110);
      s_addr[AW +: AW] = '0;
      s_din[DW +: DW]  = '0;
      s_wmask[7:4]     = '0;
      tick();
      tick();
      chk("wr_hold", {m_addr, m_din, m_wmask}, {25'h1FFFFFF, 32'hA5A5_5A5A, 4'b0110});
      serve(1, 25'h1FFFFFF, 32'h0BAD_F00D, 1'b0, 0);

      // Fairness: both ports hold requests continuously
      s_addr[0 +: AW]  = 25'h100;
      s_addr[AW +: AW] = 25'h200;
      s_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         serve(k % 2, (k % 2 == 1) ? 25'h200 : 25'h100, 32'h1000 + k, k < 4, 1);
      end

      // Port 0 drops s_valid before completion but still gets its pulse
      s_addr[0 +: AW] = 25'h0ABCDE;
      s_valid = 2'b01;
      tick();
      s_valid = 2'b00;
      serve(0, 25'h0ABCDE, 32'hCAFE_0001, 1'b0, 0);

      // Asynchronous reset during BUSY
      s_addr[0 +: AW] = 25'h55;
      s_valid = 2'b01;
      tick();
      chk("prerst_mvalid", m_valid, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_mvalid", m_valid, 0);
      chk("arst_sready", s_ready, 0);
      chk("arst_sdout", s_dout, 0);
      s_valid = 2'b00;
      tick();
      resetn = 1'b1;
      tick();

      // First contention after reset goes to port 0, then port 1
      s_addr[0 +: AW]  = 25'h100;
      s_addr[AW +: AW] = 25'h200;
      s_valid = 2'b11;
      serve(0, 25'h100, 32'h2000, 1'b0, 1);
      serve(1, 25'h200, 32'h2001, 1'b0, 1);

      // Three-port rotation with all ports requesting
      for (int i = 0; i < 3; i++) s3_addr[i*AW +: AW] = 25'h300 + i;
      s3_valid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         int cnt;
         int e;
         cnt = 0;
         e   = k % 3;
         while (m3_valid !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
         end
         chk("p3_grant_seen", m3_valid, 1);
         chk("p3_grant_addr", m3_addr, 25'h300 + e);
         chk("p3_mfields", {m3_din, m3_wmask}, 0);
         m3_dout  = 32'h3000 + k;
         m3_ready = 1'b1;
         tick();
         m3_ready = 1'b0;
         chk("p3_ready", s3_ready, 3'b001 << e);
         chk("p3_dout", s3_dout, 32'h3000 + k);
         if (k == 3) s3_valid = 3'b000;
         tick();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
